// File: rtl/sprite_frame_writer.sv
// Walks a latched render list and copies opaque, on-screen sprite pixels from the sprite ROM
// into the framebuffer through a two-stage pipeline with framebuffer backpressure.
module sprite_frame_writer #(
  parameter int unsigned    NElem       = 11,
  parameter int unsigned    FbW         = 800,
  parameter int unsigned    FbH         = 480,
  parameter int unsigned    RomW        = 1024,
  parameter int unsigned    PixW        = 16,
  parameter logic [PixW-1:0] Transparent = 16'hF81F
) (
  input  logic                 clk_33_i,
  input  logic                 rst_n,
  input  logic                 frame_start_i,
  input  logic [NElem*72-1:0]  elements_all_i,
  output logic [19:0]          rom_addr_o,
  output logic                 rom_en_o,
  input  logic [PixW-1:0]      rom_data_i,
  output logic [18:0]          fb_addr_o,
  output logic [PixW-1:0]      fb_data_o,
  output logic                 fb_we_o,
  input  logic                 fb_ready_i,
  output logic                 busy_o,
  output logic                 write_finished_o
);

  localparam int unsigned IdxW = $clog2(NElem + 1);

  typedef enum logic [2:0] {StIdle, StLatch, StElem, StDraw, StDrain, StDone} state_e;

  state_e                     state_q, state_d;
  logic [NElem-1:0][71:0]     snap_q, snap_d;
  logic [IdxW-1:0]            idx_q, idx_d, idx_sel;
  logic [11:0]                dx_q, dx_d, dy_q, dy_d;
  logic                       s2_valid_q, s2_valid_d;
  logic [12:0]                s2_px_q, s2_px_d, s2_py_q, s2_py_d;
  logic                       skid_valid_q, skid_valid_d;
  logic [PixW-1:0]            skid_q, skid_d;
  logic                       fb_we_q, fb_we_d;
  logic [18:0]                fb_addr_q, fb_addr_d;
  logic [PixW-1:0]            fb_data_q, fb_data_d;

  logic [71:0]     cur;
  logic [11:0]     cur_x, cur_y, cur_w, cur_h, cur_rx, cur_ry;
  logic            stall;
  logic [19:0]     rom_lin;
  logic [18:0]     fb_lin;
  logic [PixW-1:0] s2_data;

  assign idx_sel = (idx_q < IdxW'(NElem)) ? idx_q : '0;
  assign cur     = snap_q[idx_sel];
  assign {cur_x, cur_y, cur_w, cur_h, cur_rx, cur_ry} = cur;

  // A held write freezes every pipeline stage and the scan counters.
  assign stall   = fb_we_q & ~fb_ready_i;
  assign rom_lin = (20'(cur_ry) + 20'(dy_q)) * 20'(RomW) + 20'(cur_rx) + 20'(dx_q);
  assign fb_lin  = 19'(s2_py_q) * 19'(FbW) + 19'(s2_px_q);
  assign s2_data = skid_valid_q ? skid_q : rom_data_i;

  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    idx_d        = idx_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    s2_valid_d   = s2_valid_q;
    s2_px_d      = s2_px_q;
    s2_py_d      = s2_py_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    fb_we_d      = fb_we_q;
    fb_addr_d    = fb_addr_q;
    fb_data_d    = fb_data_q;
    rom_en_o     = 1'b0;

    if (!stall) begin
      s2_valid_d   = 1'b0;
      skid_valid_d = 1'b0;
      fb_we_d      = s2_valid_q && (32'(s2_px_q) < FbW) && (32'(s2_py_q) < FbH) &&
                     (s2_data != Transparent);
      fb_addr_d    = fb_lin;
      fb_data_d    = s2_data;
    end else if (s2_valid_q && !skid_valid_q) begin
      // ROM word is only valid this cycle; park it until the stall clears.
      skid_d       = rom_data_i;
      skid_valid_d = 1'b1;
    end

    unique case (state_q)
      StIdle: if (frame_start_i) state_d = StLatch;
      StLatch: begin
        snap_d  = elements_all_i;
        idx_d   = '0;
        state_d = StElem;
      end
      StElem: begin
        if (idx_q >= IdxW'(NElem)) begin
          state_d = StDrain;
        end else if (cur_w == 12'd0 || cur_h == 12'd0) begin
          idx_d = idx_q + IdxW'(1);
        end else begin
          dx_d    = '0;
          dy_d    = '0;
          state_d = StDraw;
        end
      end
      StDraw: begin
        if (!stall) begin
          rom_en_o   = 1'b1;
          s2_valid_d = 1'b1;
          s2_px_d    = {1'b0, cur_x} + {1'b0, dx_q};
          s2_py_d    = {1'b0, cur_y} + {1'b0, dy_q};
          if (dx_q == cur_w - 12'd1) begin
            dx_d = '0;
            if (dy_q == cur_h - 12'd1) begin
              idx_d   = idx_q + IdxW'(1);
              state_d = StElem;
            end else begin
              dy_d = dy_q + 12'd1;
            end
          end else begin
            dx_d = dx_q + 12'd1;
          end
        end
      end
      StDrain: if (!s2_valid_q && !stall) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_33_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      snap_q       <= '0;
      idx_q        <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      s2_valid_q   <= 1'b0;
      s2_px_q      <= '0;
      s2_py_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      idx_q        <= idx_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      s2_valid_q   <= s2_valid_d;
      s2_px_q      <= s2_px_d;
      s2_py_q      <= s2_py_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_data_q    <= fb_data_d;
    end
  end

  assign rom_addr_o       = (state_q == StDraw) ? rom_lin : '0;
  assign fb_we_o          = fb_we_q;
  assign fb_addr_o        = fb_addr_q;
  assign fb_data_o        = fb_data_q;
  assign busy_o           = (state_q == StLatch) || (state_q == StElem) ||
                            (state_q == StDraw) || (state_q == StDrain);
  assign write_finished_o = (state_q == StDone);

endmodule

// File: tb/tb_sprite_frame_writer.sv
// Randomized scoreboard bench for sprite_frame_writer against a pixel-level reference model.
module tb_sprite_frame_writer;

  localparam int N = 11;
  localparam logic [15:0] T = 16'hF81F;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_start = 1'b0;
  logic [N*72-1:0]   elements = '0;
  logic [19:0]       rom_addr;
  logic              rom_en;
  logic [15:0]       rom_data = '0;
  logic [18:0]       fb_addr;
  logic [15:0]       fb_data;
  logic              fb_we;
  logic              fb_ready = 1'b1;
  logic              busy;
  logic              write_finished;

  sprite_frame_writer dut (
    .clk_33_i         (clk),
    .rst_n            (rst_n),
    .frame_start_i    (frame_start),
    .elements_all_i   (elements),
    .rom_addr_o       (rom_addr),
    .rom_en_o         (rom_en),
    .rom_data_i       (rom_data),
    .fb_addr_o        (fb_addr),
    .fb_data_o        (fb_data),
    .fb_we_o          (fb_we),
    .fb_ready_i       (fb_ready),
    .busy_o           (busy),
    .write_finished_o (write_finished)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [18:0] addr; logic [15:0] data;} wr_t;
  wr_t exp_q[$];

  int e_x[N], e_y[N], e_w[N], e_h[N], e_rx[N], e_ry[N];
  int rom_mode = 0;
  int n_checks = 0, n_pass = 0;
  int n_wr = 0, wf_count = 0;
  logic bp_en = 1'b0, force_mode = 1'b0;
  int force_at = 0;

  function automatic logic [15:0] rom_fn(logic [19:0] a);
    logic [15:0] d;
    case (rom_mode)
      0: d = a[15:0];
      1: d = a[0] ? T : a[15:0];
      default: begin
        d = 16'(a * 20'h9E37) ^ 16'(a >> 3);
        if (a[2:0] == 3'd3) d = T;
        else if (d == T) d = 16'h0001;
      end
    endcase
    return d;
  endfunction

  task automatic check(string name, longint unsigned act, longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Sprite ROM: one-cycle read latency, garbage when not enabled.
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_fn(rom_addr);
    else rom_data <= 16'($urandom);
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && fb_we && fb_ready) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%0h, expected no write", fb_addr,
                 fb_data);
      end else begin
        e = exp_q.pop_front();
        check("fb_write", {fb_addr, fb_data}, {e.addr, e.data});
      end
    end
    if (rst_n && write_finished) wf_count++;
  end

  // Framebuffer ready driver.
  initial begin
    int lo = 0;
    logic fired = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!force_mode) fired = 1'b0;
      if (force_mode && !fired && n_wr == force_at) begin
        lo = 5;
        fired = 1'b1;
      end
      if (lo > 0) begin
        fb_ready = 1'b0;
        lo--;
      end else if (bp_en) fb_ready = ($urandom_range(0, 3) != 0);
      else fb_ready = 1'b1;
    end
  end

  task automatic set_elem(int i, int x, int y, int w, int h, int rx, int ry);
    e_x[i] = x; e_y[i] = y; e_w[i] = w; e_h[i] = h; e_rx[i] = rx; e_ry[i] = ry;
  endtask

  task automatic clear_elems();
    for (int i = 0; i < N; i++) set_elem(i, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++)
      elements[i*72 +: 72] = {12'(e_x[i]), 12'(e_y[i]), 12'(e_w[i]), 12'(e_h[i]),
                              12'(e_rx[i]), 12'(e_ry[i])};
  endtask

  // Reference: every element in index order, row-major, keep opaque on-screen pixels.
  task automatic model_frame(output int cnt, output int pix);
    cnt = 0;
    pix = 0;
    for (int i = 0; i < N; i++)
      for (int dy = 0; dy < e_h[i]; dy++)
        for (int dx = 0; dx < e_w[i]; dx++) begin
          int px = e_x[i] + dx;
          int py = e_y[i] + dy;
          int ra = ((e_ry[i] + dy) * 1024 + e_rx[i] + dx) % (1 << 20);
          logic [15:0] d = rom_fn(20'(ra));
          wr_t w;
          pix++;
          if (px < 800 && py < 480 && d != T) begin
            w.addr = 19'(py * 800 + px);
            w.data = d;
            exp_q.push_back(w);
            cnt++;
          end
        end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  task automatic run_frame(string name);
    int wf0 = wf_count;
    int nw0 = n_wr;
    int cnt, pix, budget;
    logic found = 1'b0;
    pack();
    model_frame(cnt, pix);
    budget = 4 * (pix + 2 * N) + 100;
    pulse_start();
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #1;
      if (wf_count > wf0) begin
        found = 1'b1;
        break;
      end
    end
    check({name, "_finished"}, found, 1);
    check({name, "_write_count"}, n_wr - nw0, cnt);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    repeat (3) @(negedge clk);
    #1;
    check({name, "_one_pulse"}, wf_count - wf0, 1);
    check({name, "_idle"}, busy, 0);
    exp_q.delete();
  endtask

  initial begin
    int wf0, nw0, cnt, pix;
    logic found, busy_ok;

    repeat (3) @(posedge clk);
    #1;
    check("rst_fb_we", fb_we, 0);
    check("rst_rom_en", rom_en, 0);
    check("rst_busy", busy, 0);
    check("rst_write_finished", write_finished, 0);
    check("rst_addrs", {fb_addr, rom_addr, fb_data}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);

    // Basic 2x2 sprite.
    clear_elems();
    set_elem(0, 10, 20, 2, 2, 0, 0);
    run_frame("t1_2x2");

    // Empty list timing and busy.
    clear_elems();
    pack();
    wf0 = wf_count;
    nw0 = n_wr;
    found = 1'b0;
    busy_ok = 1'b1;
    pulse_start();
    for (int c = 1; c <= N + 4; c++) begin
      @(negedge clk);
      #1;
      if (wf_count > wf0) begin
        found = 1'b1;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    check("t2_finished_in_time", found, 1);
    check("t2_busy_between", busy_ok, 1);
    check("t2_no_writes", n_wr - nw0, 0);

    // Corner clipping.
    clear_elems();
    set_elem(0, 799, 479, 3, 2, 0, 0);
    run_frame("t3_corner");

    // Transparent on odd dx.
    rom_mode = 1;
    clear_elems();
    set_elem(0, 100, 100, 4, 1, 0, 0);
    run_frame("t4_transparent");
    rom_mode = 0;

    // Five-cycle backpressure mid 8x1 sprite.
    clear_elems();
    set_elem(0, 300, 200, 8, 1, 5, 3);
    force_at = n_wr + 3;
    force_mode = 1'b1;
    run_frame("t5_backpressure");
    force_mode = 1'b0;

    // Second frame_start while busy ignored; input change after latch ignored.
    clear_elems();
    set_elem(0, 50, 50, 3, 3, 7, 7);
    set_elem(4, 52, 51, 2, 2, 0, 9);
    pack();
    model_frame(cnt, pix);
    wf0 = wf_count;
    pulse_start();
    repeat (2) @(posedge clk);
    #1;
    elements = ~elements;
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
    repeat (60) @(negedge clk);
    #1;
    check("t6_single_finish", wf_count - wf0, 1);
    check("t6_queue_empty", exp_q.size(), 0);
    check("t6_idle", busy, 0);
    exp_q.delete();

    // Reset mid-draw.
    clear_elems();
    set_elem(0, 0, 0, 20, 20, 0, 0);
    pack();
    model_frame(cnt, pix);
    wf0 = wf_count;
    nw0 = n_wr;
    found = 1'b0;
    pulse_start();
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      #1;
      if (n_wr - nw0 >= 10) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_reset_reached_draw", found, 1);
    rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", {fb_we, rom_en, busy, write_finished, fb_addr, rom_addr, fb_data},
          0);
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check("t6_no_finish_after_reset", wf_count - wf0, 0);
    check("t6_no_busy_after_reset", busy, 0);

    clear_elems();
    set_elem(0, 10, 20, 2, 2, 0, 0);
    run_frame("t6_recover");

    // Random frames with random backpressure and ROM contents.
    rom_mode = 2;
    bp_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++)
        set_elem(i, $urandom_range(0, 810), $urandom_range(0, 490), $urandom_range(0, 6),
                 $urandom_range(0, 5), $urandom_range(0, 1023), $urandom_range(0, 1023));
      run_frame("rand");
    end
    bp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
